design_1_spi_sensor: RTL and testbench

Top-level SPI sensor acquisition block. Host endpoint wires and triggers (OpalKelly-style `epXX`) configure and start a repeating sequence of 16-bit SPI frames to an external sensor. Each frame's returned MISO word is tagged and pushed into a 32-bit FIFO, which the host drains through a pipe-out handshake. Host-interface pins are pass-through placeholders; all logic runs on `clk`.

---
 rtl/design_1_spi_sensor.sv | 183 ++++++++++++++++++
 tb/tb_design_1_spi_sensor.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/design_1_spi_sensor.sv
// rtl/design_1_spi_sensor.sv - SPI sensor sequencer with tagged 32-bit FWFT result FIFO
// Host wires/triggers start repeating 80-cycle SPI frames; each returned word is tagged and queued.
module design_1_spi_sensor #(
  parameter int FIFO_DEPTH  = 1024,
  parameter int BLOCK_WORDS = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] ep00wirein,
  input  logic [31:0] ep01wirein,
  input  logic [31:0] ep02wirein,
  input  logic [31:0] ep03wirein,
  input  logic [31:0] ep04wirein,
  input  logic [31:0] ep05wirein,
  input  logic [31:0] ep40trigin,
  input  logic [31:0] ep41trigin,
  output logic [31:0] ep22wireout,
  output logic [31:0] ep24wireout,
  output logic [31:0] ep24wireout_readout,
  output logic [31:0] FIFO_data_out,
  input  logic        FIFO_read_from,
  output logic        pipeout_rdy,
  output logic [7:0]  led,
  output logic        spi_sclk,
  output logic        spi_cs_b,
  output logic        spi_mosi,
  input  logic        spi_miso,
  input  logic [4:0]  okUH,
  input  logic        sys_clk_p,
  input  logic        sys_clk_n,
  output logic [2:0]  okHU,
  inout  wire  [31:0] okUHU,
  inout  wire         okAA
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {IDLE, SETUP, SHIFT, GAP} state_t;
  state_t state, next_state;

  logic        rst;
  logic [6:0]  cyc;
  logic [6:0]  sh;
  logic [3:0]  bit_idx;
  logic [5:0]  chan, last_chan, chan_next;
  logic        single_mode, stop_pending;
  logic [15:0] tx_word, rx_word;
  logic [31:0] seq_cnt, readout;
  logic        start_ev, single_ev, stop_ev;
  logic        frame_end, last_frame, go_idle, frame_entry, busy;

  logic [31:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] fifo_count;
  logic          overflow, fifo_full, fifo_empty;
  logic          push_req, do_push, do_pop, flush;
  logic [31:0]   push_word;
  logic [10:0]   count_field;
  logic          unused_bits;

  assign rst       = reset | ep00wirein[0];
  assign stop_ev   = ep41trigin[2];
  assign start_ev  = ep41trigin[0] & ~stop_ev;
  assign single_ev = ep41trigin[1] & ~stop_ev;
  assign busy      = (state != IDLE);

  assign frame_end  = (state == GAP) && (cyc == 7'd79);
  assign last_frame = (chan == last_chan);
  assign go_idle    = stop_pending | stop_ev | (last_frame & single_mode);

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start_ev | single_ev) next_state = SETUP;
      SETUP:   if (cyc == 7'd3) next_state = SHIFT;
      SHIFT:   if (cyc == 7'd67) next_state = GAP;
      GAP:     if (cyc == 7'd79) next_state = go_idle ? IDLE : SETUP;
      default: next_state = IDLE;
    endcase
  end

  // A new frame starts whenever SETUP is entered from IDLE or from the previous GAP.
  assign frame_entry = (state != SETUP) && (next_state == SETUP);
  assign chan_next   = (state == IDLE || last_frame) ? 6'd0 : chan + 6'd1;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cyc          <= 7'd0;
      chan         <= 6'd0;
      last_chan    <= 6'd0;
      single_mode  <= 1'b0;
      stop_pending <= 1'b0;
      tx_word      <= 16'd0;
      rx_word      <= 16'd0;
      seq_cnt      <= 32'd0;
    end else begin
      cyc <= (frame_entry || next_state == IDLE) ? 7'd0 : cyc + 7'd1;
      if (frame_entry) begin
        chan    <= chan_next;
        tx_word <= ep01wirein[31] ? ep01wirein[15:0] : {2'b00, chan_next, 8'h00};
        if (state == IDLE || last_frame) last_chan <= ep05wirein[5:0];
      end
      if (state == IDLE) begin
        single_mode  <= single_ev & ~start_ev;
        stop_pending <= 1'b0;
      end else if (stop_ev) begin
        stop_pending <= 1'b1;
      end
      if (state == SHIFT && sh[1:0] == 2'd2) rx_word <= {rx_word[14:0], spi_miso};
      if (frame_end && last_frame) seq_cnt <= seq_cnt + 32'd1;
    end
  end

  // Offset into the shift window: bits 5:2 select the bit, bit 1 is the SCLK phase.
  assign sh       = cyc - 7'd4;
  assign bit_idx  = sh[5:2];
  assign spi_cs_b = !(state == SETUP || state == SHIFT);
  assign spi_sclk = (state == SHIFT) && sh[1];

  always_comb begin
    spi_mosi = 1'b0;
    case (state)
      SETUP:   spi_mosi = tx_word[15];
      SHIFT:   spi_mosi = tx_word[4'd15 - bit_idx];
      default: spi_mosi = 1'b0;
    endcase
  end

  assign push_req   = (state == GAP) && (cyc == 7'd68);
  assign push_word  = {seq_cnt[7:0], 2'b00, chan, rx_word};
  assign fifo_full  = (fifo_count == CW'(FIFO_DEPTH));
  assign fifo_empty = (fifo_count == '0);
  assign do_push    = push_req & ~fifo_full;
  assign do_pop     = FIFO_read_from & ~fifo_empty;
  assign flush      = ep40trigin[0];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_word;
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      overflow   <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      fifo_count <= fifo_count + 1'b1;
      else if (!do_push && do_pop) fifo_count <= fifo_count - 1'b1;
      if (push_req && fifo_full) overflow <= 1'b1;
    end
  end

  // The readout mirrors every completed frame, including ones dropped on a full FIFO.
  always_ff @(posedge clk) begin
    if (rst)           readout <= 32'd0;
    else if (push_req) readout <= push_word;
  end

  assign count_field         = 11'(fifo_count);
  assign FIFO_data_out       = fifo_empty ? 32'd0 : mem[rd_ptr];
  assign pipeout_rdy         = (fifo_count >= CW'(BLOCK_WORDS)) | ep00wirein[1];
  assign ep22wireout         = {overflow, busy, 3'b000, count_field, 16'h0000};
  assign ep24wireout         = seq_cnt;
  assign ep24wireout_readout = readout;
  assign led                 = {6'b000000, overflow, busy};
  assign okHU                = 3'b000;
  assign okUHU               = 32'hzzzz_zzzz;
  assign okAA                = 1'bz;

  assign unused_bits = ^{ep00wirein[31:2], ep01wirein[30:16], ep02wirein, ep03wirein,
                         ep04wirein, ep05wirein[31:6], ep40trigin[31:1], ep41trigin[31:3],
                         okUH, sys_clk_p, sys_clk_n, sh[6], sh[0]};

endmodule

// File: tb/tb_design_1_spi_sensor.sv
// tb/tb_design_1_spi_sensor.sv - directed/randomized bench for design_1_spi_sensor
// A mode-0 sensor model shifts a pattern out on MISO; a bus monitor records each frame.
module tb_design_1_spi_sensor;

  localparam int DEPTH = 64;
  localparam int BLK   = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] ep00wirein, ep01wirein, ep02wirein, ep03wirein, ep04wirein, ep05wirein;
  logic [31:0] ep40trigin, ep41trigin;
  logic [31:0] ep22wireout, ep24wireout, ep24wireout_readout, FIFO_data_out;
  logic        FIFO_read_from;
  logic        pipeout_rdy;
  logic [7:0]  led;
  logic        spi_sclk, spi_cs_b, spi_mosi;
  logic        spi_miso = 1'b0;
  logic [4:0]  okUH;
  logic        sys_clk_p, sys_clk_n;
  logic [2:0]  okHU;
  wire  [31:0] ok_uhu;
  wire         ok_aa;

  design_1_spi_sensor #(.FIFO_DEPTH(DEPTH), .BLOCK_WORDS(BLK)) dut (
    .clk(clk), .reset(reset),
    .ep00wirein(ep00wirein), .ep01wirein(ep01wirein), .ep02wirein(ep02wirein),
    .ep03wirein(ep03wirein), .ep04wirein(ep04wirein), .ep05wirein(ep05wirein),
    .ep40trigin(ep40trigin), .ep41trigin(ep41trigin),
    .ep22wireout(ep22wireout), .ep24wireout(ep24wireout),
    .ep24wireout_readout(ep24wireout_readout), .FIFO_data_out(FIFO_data_out),
    .FIFO_read_from(FIFO_read_from), .pipeout_rdy(pipeout_rdy), .led(led),
    .spi_sclk(spi_sclk), .spi_cs_b(spi_cs_b), .spi_mosi(spi_mosi), .spi_miso(spi_miso),
    .okUH(okUH), .sys_clk_p(sys_clk_p), .sys_clk_n(sys_clk_n), .okHU(okHU),
    .okUHU(ok_uhu), .okAA(ok_aa)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc_n = 0;
  always @(posedge clk) cyc_n <= cyc_n + 1;

  typedef struct { logic [15:0] word; int low; int nbits; } frame_t;
  frame_t mon_q[$];
  int     fall_q[$];
  logic [15:0] miso_pat = 16'hA5C3;
  logic [15:0] mbits = 16'h0;
  logic prev_cs = 1'b1, prev_sclk = 1'b0;
  int mlow = 0, mn = 0, sidx = 0;

  always @(negedge clk) begin
    if (!spi_cs_b && prev_cs) begin
      fall_q.push_back(cyc_n);
      mlow = 0; mn = 0; mbits = 16'h0; sidx = 0;
    end
    if (!spi_cs_b) begin
      mlow++;
      if (!prev_sclk && spi_sclk) begin mbits = {mbits[14:0], spi_mosi}; mn++; end
      if (prev_sclk && !spi_sclk) sidx++;
    end else if (!prev_cs) begin
      mon_q.push_back('{mbits, mlow, mn});
    end
    if (spi_cs_b) sidx = 0;
    spi_miso  = (!spi_cs_b && sidx < 16) ? miso_pat[15 - sidx] : 1'b0;
    prev_cs   = spi_cs_b;
    prev_sclk = spi_sclk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse41(input logic [31:0] v);
    ep41trigin = v;
    step(1);
    ep41trigin = 32'h0;
  endtask

  task automatic pop_check(input string tag, input logic [31:0] exp);
    check(tag, FIFO_data_out, exp);
    FIFO_read_from = 1'b1;
    step(1);
    FIFO_read_from = 1'b0;
  endtask

  function automatic logic [31:0] exp_word(input int seqn, input int k, input logic [15:0] p);
    return {seqn[7:0], 2'b00, k[5:0], p};
  endfunction

  function automatic logic [15:0] chan_cmd(input int k);
    return {2'b00, k[5:0], 8'h00};
  endfunction

  initial begin
    int t, ftotal, base, nseq_b, r, n_d;
    reset = 1'b1;
    ep00wirein = 0; ep01wirein = 0; ep02wirein = 0; ep03wirein = 0; ep04wirein = 0;
    ep05wirein = 0; ep40trigin = 0; ep41trigin = 0; FIFO_read_from = 1'b0;
    okUH = 5'h0; sys_clk_p = 1'b0; sys_clk_n = 1'b1;
    step(3);
    reset = 1'b0;
    step(1);

    check("rst_cs_b", spi_cs_b, 1);
    check("rst_sclk", spi_sclk, 0);
    check("rst_mosi", spi_mosi, 0);
    check("rst_status", ep22wireout, 0);
    check("rst_seq", ep24wireout, 0);
    check("rst_readout", ep24wireout_readout, 0);
    check("rst_fifo_out", FIFO_data_out, 0);
    check("rst_pipeout", pipeout_rdy, 0);
    check("rst_led", led, 0);
    check("rst_okhu", okHU, 0);

    // Continuous 32-channel run, stopped mid-frame somewhere in the second sequence.
    ep05wirein = 31;
    miso_pat = 16'hA5C3;
    mon_q.delete(); fall_q.delete();
    pulse41(32'h1);
    check("a_start_cs_low", spi_cs_b, 0);
    check("a_busy", led[0], 1);
    step(2559);
    check("a_seq_before", ep24wireout, 0);
    step(1);
    check("a_seq_after", ep24wireout, 1);
    t = 2641 + $urandom_range(0, 1999);
    ftotal = (t - 1) / 80 + 1;
    step(t - 1 - 2560);
    pulse41(32'h4);
    step(200);
    check("a_stopped_busy", led[0], 0);
    check("a_stopped_cs", spi_cs_b, 1);
    check("a_frames", mon_q.size(), ftotal);
    for (int i = 0; i < mon_q.size() && i < ftotal; i++) begin
      check("a_mosi_word", mon_q[i].word, chan_cmd(i % 32));
      check("a_cs_low_len", mon_q[i].low, 68);
      check("a_nbits", mon_q[i].nbits, 16);
    end
    for (int i = 1; i < fall_q.size(); i++) check("a_frame_period", fall_q[i] - fall_q[i-1], 80);
    check("a_seq_count", ep24wireout, ftotal / 32);
    check("a_fifo_count", ep22wireout[26:16], ftotal);
    check("a_overflow", ep22wireout[31], 0);
    check("a_readout", ep24wireout_readout, exp_word((ftotal - 1) / 32, (ftotal - 1) % 32, 16'hA5C3));
    check("a_pipeout", pipeout_rdy, (ftotal >= BLK) ? 1 : 0);
    for (int f = 0; f < ftotal; f++) pop_check("a_fifo_word", exp_word(f / 32, f % 32, 16'hA5C3));
    check("a_drained_count", ep22wireout[26:16], 0);
    check("a_drained_out", FIFO_data_out, 0);
    check("a_pipeout_low", pipeout_rdy, 0);
    ep00wirein = 32'h2;
    step(1);
    check("a_pipeout_override", pipeout_rdy, 1);
    ep00wirein = 32'h0;

    // Six-channel continuous run, never drained, until the FIFO overflows.
    base = ftotal / 32;
    ep05wirein = 5;
    miso_pat = 16'($urandom);
    mon_q.delete(); fall_q.delete();
    pulse41(32'h1);
    step(479);
    check("b_seq_479", ep24wireout, base);
    step(1);
    check("b_seq_480", ep24wireout, base + 1);
    step(479);
    check("b_seq_959", ep24wireout, base + 1);
    step(1);
    check("b_seq_960", ep24wireout, base + 2);
    ep41trigin = 32'h2;
    step(1);
    ep41trigin = 32'h0;
    step(5600 - 961);
    check("b_count_sat", ep22wireout[26:16], DEPTH);
    check("b_overflow", ep22wireout[31], 1);
    check("b_led_ovf", led[1], 1);
    check("b_led_busy", led[0], 1);
    check("b_pipeout", pipeout_rdy, 1);
    check("b_readout", ep24wireout_readout, exp_word(base + 69 / 6, 69 % 6, miso_pat));
    for (int i = 0; i < 12 && i < mon_q.size(); i++) check("b_mosi_word", mon_q[i].word, chan_cmd(i % 6));
    pulse41(32'h4);
    nseq_b = 71 / 6;
    step(200);
    check("b_stopped_busy", led[0], 0);
    check("b_frames", mon_q.size(), 71);
    check("b_seq_count", ep24wireout, base + nseq_b);
    for (int f = 0; f < 8; f++) pop_check("b_fifo_word", exp_word(base + f / 6, f % 6, miso_pat));
    check("b_ovf_sticky", ep22wireout[31], 1);
    ep40trigin = 32'h1;
    step(1);
    ep40trigin = 32'h0;
    check("b_flush_count", ep22wireout[26:16], 0);
    check("b_flush_ovf", ep22wireout[31], 0);
    check("b_flush_led", led, 0);
    check("b_flush_out", FIFO_data_out, 0);

    // Single 4-frame sequence, with exact push visibility and return to IDLE.
    base = base + nseq_b;
    ep05wirein = 3;
    miso_pat = 16'($urandom);
    mon_q.delete(); fall_q.delete();
    pulse41(32'h2);
    step(68);
    check("c_count_c68", ep22wireout[26:16], 0);
    step(1);
    check("c_count_c69", ep22wireout[26:16], 1);
    check("c_head_c69", FIFO_data_out, exp_word(base, 0, miso_pat));
    step(319 - 69);
    check("c_busy_319", led[0], 1);
    step(1);
    check("c_busy_320", led[0], 0);
    step(20);
    check("c_frames", mon_q.size(), 4);
    check("c_seq_count", ep24wireout, base + 1);
    check("c_count", ep22wireout[26:16], 4);
    check("c_pipeout", pipeout_rdy, 0);
    ep00wirein = 32'h2;
    step(1);
    check("c_pipeout_override", pipeout_rdy, 1);
    ep00wirein = 32'h0;
    for (int f = 0; f < 4; f++) pop_check("c_fifo_word", exp_word(base, f, miso_pat));
    FIFO_read_from = 1'b1;
    step(1);
    FIFO_read_from = 1'b0;
    check("c_pop_empty_count", ep22wireout[26:16], 0);
    check("c_pop_empty_out", FIFO_data_out, 0);
    pulse41(32'h5);
    step(3);
    check("c_stop_wins", led[0], 0);
    check("c_stop_wins_cs", spi_cs_b, 1);

    // Literal command, then soft reset in the middle of the third frame.
    ep01wirein = 32'h8000_C0DE;
    n_d = $urandom_range(2, 5);
    ep05wirein = n_d;
    miso_pat = 16'($urandom);
    mon_q.delete(); fall_q.delete();
    pulse41(32'h1);
    r = $urandom_range(4, 60);
    step(160 + r);
    check("d_frames", mon_q.size(), 2);
    for (int i = 0; i < 2 && i < mon_q.size(); i++) check("d_literal", mon_q[i].word, 16'hC0DE);
    check("d_count", ep22wireout[26:16], 2);
    check("d_mid_cs", spi_cs_b, 0);
    check("d_readout", ep24wireout_readout, exp_word(base + 1, 1, miso_pat));
    ep00wirein = 32'h1;
    step(1);
    check("d_rst_cs", spi_cs_b, 1);
    check("d_rst_sclk", spi_sclk, 0);
    check("d_rst_mosi", spi_mosi, 0);
    check("d_rst_status", ep22wireout, 0);
    check("d_rst_seq", ep24wireout, 0);
    check("d_rst_readout", ep24wireout_readout, 0);
    check("d_rst_out", FIFO_data_out, 0);
    ep00wirein = 32'h0;
    ep01wirein = 32'h0;
    step(5);
    check("d_after_idle", led, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
